// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared codes for the 5-stage hazard sequencer: forwarding selects, FSM states, NOP field values.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_NUM_W = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MA  = 2'd2;
  localparam logic [1:0] FWD_RW  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Field values the stage registers load when bubble_ex / flush_id is asserted
  localparam int   NOP_ALUCODE  = 0;
  localparam logic NOP_REG_WE   = 1'b0;
  localparam logic NOP_IS_STORE = 1'b0;

  typedef struct packed {
    logic [REG_NUM_W-1:0] num;
    logic                 we;
  } wb_tag_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand source select for one ID source register: youngest producer wins, x0 never forwards.
module forward_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_NUM_W-1:0] src_num,
  input  logic                 use_src,
  input  wb_tag_t              ex_tag,
  input  logic                 is_load_ex,
  input  wb_tag_t              ma_tag,
  input  wb_tag_t              rw_tag,
  output logic [1:0]           fwd_sel
);

  always_comb begin
    fwd_sel = FWD_REG;
    if (use_src && (src_num != '0)) begin
      // a load in EX has no data yet; the load-use stall covers it
      if (ex_tag.we && !is_load_ex && (ex_tag.num == src_num)) fwd_sel = FWD_EX;
      else if (ma_tag.we && (ma_tag.num == src_num))           fwd_sel = FWD_MA;
      else if (rw_tag.we && (rw_tag.num == src_num))           fwd_sel = FWD_RW;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the IF/ID/EX/MA/RW pipe: enables, flush/bubble, load-use stall, halt drain.
// Define PERF_COUNTERS_EN to add stall_cnt/flush_cnt/wait_cnt event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
`ifdef PERF_COUNTERS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_NUM_W-1:0] src1_num_id,
  input  logic [REG_NUM_W-1:0] src2_num_id,
  input  logic                 use_src1_id,
  input  logic                 use_src2_id,
  input  logic [REG_NUM_W-1:0] dst_num_ex,
  input  logic                 reg_we_ex,
  input  logic                 is_load_ex,
  input  logic                 is_halt_ex,
  input  logic                 br_redirect_ex,
  input  logic [REG_NUM_W-1:0] dst_num_ma,
  input  logic                 reg_we_ma,
  input  logic [REG_NUM_W-1:0] dst_num_rw,
  input  logic                 reg_we_rw,
  input  logic                 mem_wait,
  output logic                 en_if,
  output logic                 en_id,
  output logic                 en_ex,
  output logic                 bubble_ex,
  output logic                 flush_id,
  output logic                 pc_redirect,
  output logic [1:0]           fwd_sel1,
  output logic [1:0]           fwd_sel2,
  output logic                 halted
`ifdef PERF_COUNTERS_EN
  , output logic [CNT_W-1:0]   stall_cnt
  , output logic [CNT_W-1:0]   flush_cnt
  , output logic [CNT_W-1:0]   wait_cnt
`endif
);

  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

  state_e          state_q, state_d;
  logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            halted_q, halted_d;
  logic [1:0]      fwd1_raw, fwd2_raw;
  logic            load_use;
  wb_tag_t         ex_tag, ma_tag, rw_tag;

  assign ex_tag = '{num: dst_num_ex, we: reg_we_ex};
  assign ma_tag = '{num: dst_num_ma, we: reg_we_ma};
  assign rw_tag = '{num: dst_num_rw, we: reg_we_rw};

  forward_unit u_fwd1 (
    .src_num(src1_num_id), .use_src(use_src1_id), .ex_tag(ex_tag), .is_load_ex(is_load_ex),
    .ma_tag(ma_tag), .rw_tag(rw_tag), .fwd_sel(fwd1_raw)
  );

  forward_unit u_fwd2 (
    .src_num(src2_num_id), .use_src(use_src2_id), .ex_tag(ex_tag), .is_load_ex(is_load_ex),
    .ma_tag(ma_tag), .rw_tag(rw_tag), .fwd_sel(fwd2_raw)
  );

  assign load_use = reg_we_ex && is_load_ex && (dst_num_ex != '0) &&
                    ((use_src1_id && (src1_num_id == dst_num_ex)) ||
                     (use_src2_id && (src2_num_id == dst_num_ex)));

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    en_if       = 1'b1;
    en_id       = 1'b1;
    en_ex       = 1'b1;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    pc_redirect = 1'b0;
    case (state_q)
      ST_HALTED: begin
        en_if = 1'b0;
        en_id = 1'b0;
        en_ex = 1'b0;
      end
      ST_DRAIN: begin
        en_if = 1'b0;
        en_id = 1'b0;
        if (mem_wait) begin
          en_ex = 1'b0;
        end else begin
          bubble_ex   = 1'b1;
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) state_d = ST_HALTED;
        end
      end
      default: begin
        if (mem_wait) begin
          en_if = 1'b0;
          en_id = 1'b0;
          en_ex = 1'b0;
        end else if (br_redirect_ex) begin
          pc_redirect = 1'b1;
          flush_id    = 1'b1;
          bubble_ex   = 1'b1;
        end else if (is_halt_ex) begin
          // halt moves on to MA behind a bubble; younger instrs are squashed
          en_if     = 1'b0;
          en_id     = 1'b0;
          bubble_ex = 1'b1;
          flush_id  = 1'b1;
          state_d   = ST_DRAIN;
        end else if (load_use) begin
          en_if     = 1'b0;
          en_id     = 1'b0;
          bubble_ex = 1'b1;
        end
      end
    endcase
    halted_d = (state_d == ST_HALTED);
    if (rst) begin
      en_if       = 1'b0;
      en_id       = 1'b0;
      en_ex       = 1'b0;
      bubble_ex   = 1'b1;
      flush_id    = 1'b1;
      pc_redirect = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign fwd_sel1 = rst ? FWD_REG : fwd1_raw;
  assign fwd_sel2 = rst ? FWD_REG : fwd2_raw;
  assign halted   = halted_q;

`ifdef PERF_COUNTERS_EN
  logic             stall_ev, flush_ev, wait_ev;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, wait_cnt_q, wait_cnt_d;

  // events count only while running; DRAIN and HALTED leave the counters untouched
  always_comb begin
    wait_ev     = (state_q == ST_RUN) && mem_wait;
    flush_ev    = (state_q == ST_RUN) && !mem_wait && br_redirect_ex;
    stall_ev    = (state_q == ST_RUN) && !mem_wait && !br_redirect_ex && !is_halt_ex && load_use;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_ev);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_ev);
    wait_cnt_d  = wait_cnt_q + CNT_W'(wait_ev);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

endmodule
